relu: RTL and testbench

- Signed rectified-linear activation for the NPU datapath, placed after the accumulator/requantize stage.
- Provides a zero-latency combinational ReLU output that depends only on `in`.
- Also provides a one-cycle registered, mode-selectable activation path (ReLU / leaky / clipped) with valid tracking and a saturation/negative statistics counter.

---
 rtl/relu.sv | 103 ++++++++++
 tb/tb_relu.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/relu.sv
// rtl/relu.sv - signed ReLU activation: combinational ReLU plus registered mode-selectable path with statistics
module relu #(
    parameter int DATA_WIDTH = 8,
    parameter int LEAK_SHIFT = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] in,
    output logic signed [DATA_WIDTH-1:0] out,
    input  logic        [1:0]            mode,
    input  logic signed [DATA_WIDTH-1:0] clip_max,
    input  logic                         in_valid,
    output logic signed [DATA_WIDTH-1:0] out_q,
    output logic                         out_valid,
    output logic        [CNT_WIDTH-1:0]  neg_count,
    output logic        [CNT_WIDTH-1:0]  clip_count,
    input  logic                         clr_stats
);

    localparam logic [1:0] MODE_RELU  = 2'b00;
    localparam logic [1:0] MODE_LEAKY = 2'b01;
    localparam logic [1:0] MODE_CLIP  = 2'b10;
    localparam logic [1:0] MODE_IDENT = 2'b11;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic                         is_neg;
    logic                         above_clip;
    logic                         clip_hit;
    logic signed [DATA_WIDTH-1:0] relu_val;
    logic signed [DATA_WIDTH-1:0] leaky_val;
    logic signed [DATA_WIDTH-1:0] act_val;

    // Zero-latency ReLU: only the sign bit of in steers it, so other inputs cannot disturb it.
    assign out = in[DATA_WIDTH-1] ? '0 : in;

    assign is_neg     = in[DATA_WIDTH-1];
    assign relu_val   = is_neg ? '0 : in;
    // Arithmetic shift floors toward -inf, so small negatives saturate at -1 rather than 0.
    assign leaky_val  = in >>> LEAK_SHIFT;
    assign above_clip = (in > clip_max);
    // A non-negative sample above the bound counts as clipped even when the bound itself is negative.
    assign clip_hit   = (mode == MODE_CLIP) && !is_neg && above_clip;

    // Select the activation function for the registered path.
    always_comb begin
        act_val = relu_val;
        case (mode)
            MODE_RELU:  act_val = relu_val;
            MODE_LEAKY: act_val = is_neg ? leaky_val : in;
            MODE_CLIP: begin
                // A negative bound forces every result to zero.
                if (is_neg || clip_max[DATA_WIDTH-1])
                    act_val = '0;
                else if (above_clip)
                    act_val = clip_max;
                else
                    act_val = in;
            end
            MODE_IDENT: act_val = in;
            default:    act_val = relu_val;
        endcase
    end

    // Capture the activation result on accepted samples; hold it otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            out_q <= '0;
        else if (in_valid)
            out_q <= act_val;
    end

    // Valid follows in_valid by one cycle; reset drops it asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            out_valid <= 1'b0;
        else
            out_valid <= in_valid;
    end

    // Saturating count of accepted negative samples; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            neg_count <= '0;
        else if (clr_stats)
            neg_count <= '0;
        else if (in_valid && is_neg && (neg_count != CNT_MAX))
            neg_count <= neg_count + CNT_ONE;
    end

    // Saturating count of accepted samples clipped in clipped mode; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            clip_count <= '0;
        else if (clr_stats)
            clip_count <= '0;
        else if (in_valid && clip_hit && (clip_count != CNT_MAX))
            clip_count <= clip_count + CNT_ONE;
    end

endmodule

// File: tb/tb_relu.sv
// tb/tb_relu.sv - scoreboard bench for relu against a behavioural activation model
module tb_relu;

    localparam int DW = 8;
    localparam int LS = 3;
    localparam int CW = 8;
    localparam int CNT_SAT = (1 << CW) - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [DW-1:0] in;
    logic signed [DW-1:0] out;
    logic        [1:0]    mode;
    logic signed [DW-1:0] clip_max;
    logic                 in_valid;
    logic signed [DW-1:0] out_q;
    logic                 out_valid;
    logic        [CW-1:0] neg_count;
    logic        [CW-1:0] clip_count;
    logic                 clr_stats;

    logic signed [DW-1:0] cin;
    logic signed [DW-1:0] cout;
    logic signed [DW-1:0] c_q;
    logic                 c_v;
    logic        [CW-1:0] c_n;
    logic        [CW-1:0] c_c;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic v;
        int   q;
        int   neg;
        int   clip;
    } exp_t;

    exp_t sb[$];

    int m_q, m_neg, m_clip;

    always #5 clk = ~clk;

    relu #(.DATA_WIDTH(DW), .LEAK_SHIFT(LS), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .in(in), .out(out), .mode(mode),
        .clip_max(clip_max), .in_valid(in_valid), .out_q(out_q),
        .out_valid(out_valid), .neg_count(neg_count), .clip_count(clip_count),
        .clr_stats(clr_stats)
    );

    relu #(.DATA_WIDTH(DW), .LEAK_SHIFT(LS), .CNT_WIDTH(CW)) u_comb (
        .clk(1'bx), .rst(1'bx), .in(cin), .out(cout), .mode(2'bxx),
        .clip_max(8'bx), .in_valid(1'bx), .out_q(c_q),
        .out_valid(c_v), .neg_count(c_n), .clip_count(c_c),
        .clr_stats(1'bz)
    );

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int floor_div(input int a, input int d);
        int q;
        q = a / d;
        if ((a % d != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int model_act(input int md, input int x, input int cm);
        int lo;
        case (md)
            0: return (x < 0) ? 0 : x;
            1: return (x >= 0) ? x : floor_div(x, 1 << LS);
            2: begin
                lo = (x < cm) ? x : cm;
                return (lo < 0) ? 0 : lo;
            end
            default: return x;
        endcase
    endfunction

    task automatic step(input logic v, input int md, input int x, input int cm, input logic clr);
        exp_t e;
        @(posedge clk);
        #2;
        in_valid  = v;
        mode      = 2'(md);
        in        = DW'(x);
        clip_max  = DW'(cm);
        clr_stats = clr;
        if (clr) begin
            m_neg  = 0;
            m_clip = 0;
        end else if (v) begin
            if (x < 0 && m_neg < CNT_SAT) m_neg++;
            if (md == 2 && x >= 0 && x > cm && m_clip < CNT_SAT) m_clip++;
        end
        if (v) m_q = model_act(md, x, cm);
        e.v = v; e.q = m_q; e.neg = m_neg; e.clip = m_clip;
        sb.push_back(e);
    endtask

    // Monitor: combinational check every cycle and scoreboard pop for registered outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            check("comb_out", int'(out), (int'(in) < 0) ? 0 : int'(in));
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("out_valid", int'(out_valid), int'(e.v));
                check("out_q", int'(out_q), e.q);
                check("neg_count", int'(neg_count), e.neg);
                check("clip_count", int'(clip_count), e.clip);
            end
        end
    end

    initial begin
        logic signed [DW-1:0] r;
        int md, cm;
        rst = 1'b1; in = '0; mode = '0; clip_max = '0; in_valid = 1'b0; clr_stats = 1'b0; cin = '0;
        m_q = 0; m_neg = 0; m_clip = 0;

        // Combinational path with every other input unknown.
        cin = 8'sh01; #1; check("comb_01", int'(cout), 1);
        cin = 8'sh00; #1; check("comb_00", int'(cout), 0);
        cin = 8'shFF; #1; check("comb_FF", int'(cout), 0);
        cin = 8'sh80; #1; check("comb_80", int'(cout), 0);
        cin = 8'sh7F; #1; check("comb_7F", int'(cout), 127);

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_q", int'(out_q), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_neg", int'(neg_count), 0);
        check("rst_clip", int'(clip_count), 0);
        @(posedge clk); #2; rst = 1'b0;

        // Registered ReLU.
        step(1, 0, 5, 0, 0); step(1, 0, -3, 0, 0); step(1, 0, 0, 0, 0);
        // Leaky.
        step(1, 1, -16, 0, 0); step(1, 1, -1, 0, 0); step(1, 1, 20, 0, 0);
        // Clipped, including a negative bound.
        step(1, 2, 10, 6, 0); step(1, 2, 4, 6, 0); step(1, 2, -5, 6, 0);
        step(1, 2, 7, -2, 0); step(1, 2, 127, 127, 0); step(1, 3, -128, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            r  = DW'($urandom);
            md = int'($urandom_range(0, 3));
            cm = int'($signed(DW'($urandom)));
            step(($urandom_range(0, 3) != 0), md, int'(r), cm, ($urandom_range(0, 63) == 0));
        end

        // Saturation then clear colliding with a negative sample.
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < (1 << CW) + 2; i++) step(1, 0, -7, 0, 0);
        step(1, 0, -7, 0, 1);
        step(1, 0, -7, 0, 0);

        // Valid gating: out_q held, out_valid low.
        step(0, 0, 33, 0, 0); step(0, 0, -9, 0, 0); step(0, 0, 44, 0, 0);

        // Mid-cycle reset.
        @(posedge clk);
        #5;
        rst = 1'b1;
        #1;
        check("midrst_out_q", int'(out_q), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_neg", int'(neg_count), 0);
        check("midrst_clip", int'(clip_count), 0);
        // A sample presented during reset is discarded.
        in_valid = 1'b1; in = -8'sd5; mode = 2'b10; clip_max = 8'sd1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0; in_valid = 1'b0;
        m_q = 0; m_neg = 0; m_clip = 0;
        step(0, 0, 0, 0, 0);
        step(1, 1, -9, 0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #3;
        if (sb.size() != 0) check("scoreboard_drain", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
